// File: rtl/plate_row_locator.sv
// plate_row_locator
// Finds the tallest vertical band of "busy" rows in a binary edge image and
// reports it as a bounding box once per frame. A row is busy when it holds
// at least ROW_EDGE_THRESHOLD edge pixels; consecutive busy rows form a run,
// and the longest run of at least MIN_RUN_ROWS rows wins the frame.
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   per_frame_vsync     frame sync; rising edge closes one frame, opens next
//   per_frame_href      line valid
//   per_frame_clken     pixel valid strobe
//   per_img_bit         edge pixel (1 = edge)
//   box_valid           one-cycle pulse when a new result is published
//   box_found           1 when the last completed frame had a candidate
//   box_top/box_bottom  first/last row of the candidate
//   box_left/box_right  min/max edge column within the candidate rows
module plate_row_locator #(
  parameter int IMG_WIDTH          = 640,
  parameter int ROW_EDGE_THRESHOLD = 20,
  parameter int MIN_RUN_ROWS       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_bit,
  output logic        box_valid,
  output logic        box_found,
  output logic [10:0] box_top,
  output logic [10:0] box_bottom,
  output logic [11:0] box_left,
  output logic [11:0] box_right
);

  // The x counter is 12 bits wide, so wider lines cannot be addressed.
  if (IMG_WIDTH < 1 || IMG_WIDTH > 4095) begin : g_bad_width
    $error("plate_row_locator: IMG_WIDTH must be in 1..4095");
  end

  localparam logic [11:0] X_MAX  = 12'hFFF;
  localparam logic [10:0] Y_MAX  = 11'h7FF;
  localparam logic [11:0] THRESH = 12'(ROW_EDGE_THRESHOLD);
  localparam logic [10:0] MINRUN = 11'(MIN_RUN_ROWS);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;

  logic        vsync_d, href_d;
  logic        vsync_rise, href_fall, pix_ok;
  logic [11:0] x_cnt, edge_cnt, row_min_x, row_max_x;
  logic [10:0] y_cnt;
  logic [10:0] run_len, run_top, run_bottom;
  logic [11:0] run_left, run_right;
  logic [10:0] best_len, best_top, best_bottom;
  logic [11:0] best_left, best_right;

  // Next-state run/best after the current row close, and the frame result
  // after additionally closing whatever run is still open.
  logic        row_qual;
  logic [10:0] r_len, r_top, r_bottom;
  logic [11:0] r_left, r_right;
  logic [10:0] b_len, b_top, b_bottom;
  logic [11:0] b_left, b_right;
  logic [10:0] f_len, f_top, f_bottom;
  logic [11:0] f_left, f_right;

  assign vsync_rise = per_frame_vsync & ~vsync_d;
  assign href_fall  = ~per_frame_href & href_d;
  assign pix_ok     = per_frame_href & per_frame_clken;

  // Row close is evaluated first and the frame close is layered on top of
  // it, so a line ending on the same cycle as vsync still counts.
  always_comb begin
    row_qual = (edge_cnt >= THRESH);
    r_len    = run_len;
    r_top    = run_top;
    r_bottom = run_bottom;
    r_left   = run_left;
    r_right  = run_right;
    b_len    = best_len;
    b_top    = best_top;
    b_bottom = best_bottom;
    b_left   = best_left;
    b_right  = best_right;
    if (href_fall) begin
      if (row_qual) begin
        if (run_len == 11'd0) begin
          r_len    = 11'd1;
          r_top    = y_cnt;
          r_bottom = y_cnt;
          r_left   = row_min_x;
          r_right  = row_max_x;
        end else begin
          if (run_len != Y_MAX) r_len = run_len + 11'd1;
          r_bottom = y_cnt;
          if (row_min_x < run_left)  r_left  = row_min_x;
          if (row_max_x > run_right) r_right = row_max_x;
        end
      end else begin
        // Strict greater-than keeps the upper run on a tie.
        if (run_len >= MINRUN && run_len > best_len) begin
          b_len    = run_len;
          b_top    = run_top;
          b_bottom = run_bottom;
          b_left   = run_left;
          b_right  = run_right;
        end
        r_len = 11'd0;
      end
    end
    f_len    = b_len;
    f_top    = b_top;
    f_bottom = b_bottom;
    f_left   = b_left;
    f_right  = b_right;
    if (r_len >= MINRUN && r_len > b_len) begin
      f_len    = r_len;
      f_top    = r_top;
      f_bottom = r_bottom;
      f_left   = r_left;
      f_right  = r_right;
    end
  end

  // Main sequencer: pixel/row accumulation, run tracking and the per-frame
  // publish. Everything is cleared at each frame start so results never
  // leak from one frame into the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vsync_d     <= 1'b0;
      href_d      <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      edge_cnt    <= '0;
      row_min_x   <= '0;
      row_max_x   <= '0;
      run_len     <= '0;
      run_top     <= '0;
      run_bottom  <= '0;
      run_left    <= '0;
      run_right   <= '0;
      best_len    <= '0;
      best_top    <= '0;
      best_bottom <= '0;
      best_left   <= '0;
      best_right  <= '0;
      box_valid   <= 1'b0;
      box_found   <= 1'b0;
      box_top     <= '0;
      box_bottom  <= '0;
      box_left    <= '0;
      box_right   <= '0;
    end else begin
      vsync_d   <= per_frame_vsync;
      href_d    <= per_frame_href;
      box_valid <= 1'b0;
      if (vsync_rise) begin
        if (state == ACTIVE) begin
          box_valid  <= 1'b1;
          box_found  <= (f_len != 11'd0);
          box_top    <= (f_len != 11'd0) ? f_top    : 11'd0;
          box_bottom <= (f_len != 11'd0) ? f_bottom : 11'd0;
          box_left   <= (f_len != 11'd0) ? f_left   : 12'd0;
          box_right  <= (f_len != 11'd0) ? f_right  : 12'd0;
        end
        state       <= ACTIVE;
        x_cnt       <= '0;
        y_cnt       <= '0;
        edge_cnt    <= '0;
        row_min_x   <= '0;
        row_max_x   <= '0;
        run_len     <= '0;
        run_top     <= '0;
        run_bottom  <= '0;
        run_left    <= '0;
        run_right   <= '0;
        best_len    <= '0;
        best_top    <= '0;
        best_bottom <= '0;
        best_left   <= '0;
        best_right  <= '0;
      end else if (state == ACTIVE) begin
        if (pix_ok) begin
          if (x_cnt != X_MAX) x_cnt <= x_cnt + 12'd1;
          if (per_img_bit) begin
            if (edge_cnt != X_MAX) edge_cnt <= edge_cnt + 12'd1;
            if (edge_cnt == 12'd0 || x_cnt < row_min_x) row_min_x <= x_cnt;
            if (edge_cnt == 12'd0 || x_cnt > row_max_x) row_max_x <= x_cnt;
          end
        end
        if (href_fall) begin
          x_cnt     <= '0;
          edge_cnt  <= '0;
          row_min_x <= '0;
          row_max_x <= '0;
          if (y_cnt != Y_MAX) y_cnt <= y_cnt + 11'd1;
        end
        run_len     <= r_len;
        run_top     <= r_top;
        run_bottom  <= r_bottom;
        run_left    <= r_left;
        run_right   <= r_right;
        best_len    <= b_len;
        best_top    <= b_top;
        best_bottom <= b_bottom;
        best_left   <= b_left;
        best_right  <= b_right;
      end
    end
  end

endmodule

// File: tb/tb_plate_row_locator.sv
// tb_plate_row_locator
// Drives 480-line frames with hand-placed edge bands into plate_row_locator.
// Each frame's expected box is queued when its closing vsync is issued; a
// monitor pops and compares whenever box_valid pulses.
module tb_plate_row_locator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b0, hr = 1'b0, ck = 1'b0, img_bit = 1'b0;
  logic        box_valid, box_found;
  logic [10:0] box_top, box_bottom;
  logic [11:0] box_left, box_right;

  typedef struct {
    logic        found;
    logic [10:0] top, bottom;
    logic [11:0] left, right;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  plate_row_locator dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr),
    .per_frame_clken(ck), .per_img_bit(img_bit),
    .box_valid(box_valid), .box_found(box_found),
    .box_top(box_top), .box_bottom(box_bottom),
    .box_left(box_left), .box_right(box_right)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int f, input int t, input int b,
                              input int l, input int r);
    exp_t e;
    e.found  = 1'(f);
    e.top    = 11'(t);
    e.bottom = 11'(b);
    e.left   = 12'(l);
    e.right  = 12'(r);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid"},  32'(box_valid),  0);
    checkOutput({tag, "_found"},  32'(box_found),  0);
    checkOutput({tag, "_top"},    32'(box_top),    0);
    checkOutput({tag, "_bottom"}, 32'(box_bottom), 0);
    checkOutput({tag, "_left"},   32'(box_left),   0);
    checkOutput({tag, "_right"},  32'(box_right),  0);
  endtask

  task automatic vsync_pulse();
    vs = 1'b1;
    tick();
    tick();
    vs = 1'b0;
    tick();
    tick();
  endtask

  // One frame of 480 lines. Up to two bands (rows t..b, edge columns l..r);
  // each line starts with an href-only cycle and is followed by a gap where
  // clken strobes without href, both of which must be ignored. The frame is
  // closed by a vsync rise, optionally on the same cycle as the last href fall.
  task automatic applyStimulus(input int t0, input int b0, input int l0, input int r0,
                               input int t1, input int b1, input int l1, input int r1,
                               input bit coincide, input int abort_row,
                               input exp_t exp_res);
    for (int y = 0; y < 480; y++) begin
      int l, r, npix;
      l = -1;
      r = -1;
      npix = 2;
      if (y >= t0 && y <= b0) begin
        l = l0;
        r = r0;
      end else if (y >= t1 && y <= b1) begin
        l = l1;
        r = r1;
      end
      if (r >= 0) npix = r + 1;
      if (y == abort_row) begin
        hr = 1'b1;
        ck = 1'b1;
        img_bit = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        hr = 1'b0;
        ck = 1'b0;
        img_bit = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      hr = 1'b1;
      ck = 1'b0;
      img_bit = 1'b1;
      tick();
      for (int x = 0; x < npix; x++) begin
        ck = 1'b1;
        img_bit = (l >= 0 && x >= l && x <= r);
        tick();
      end
      hr = 1'b0;
      ck = 1'b1;
      img_bit = 1'b1;
      if (coincide && y == 479) begin
        sb_q.push_back(exp_res);
        vs = 1'b1;
      end
      tick();
      tick();
      ck = 1'b0;
      img_bit = 1'b0;
    end
    if (!coincide) begin
      sb_q.push_back(exp_res);
      vs = 1'b1;
      tick();
      tick();
    end
    vs = 1'b0;
    tick();
    tick();
  endtask

  // Scoreboard monitor: every box_valid pulse must match the oldest queued
  // expectation; a pulse with nothing queued is itself a failure.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && box_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_box_valid: got pulse, expected none");
      end else begin
        e = sb_q.pop_front();
        checkOutput("box_found",  32'(box_found),  32'(e.found));
        checkOutput("box_top",    32'(box_top),    32'(e.top));
        checkOutput("box_bottom", 32'(box_bottom), 32'(e.bottom));
        checkOutput("box_left",   32'(box_left),   32'(e.left));
        checkOutput("box_right",  32'(box_right),  32'(e.right));
      end
    end
  end

  initial begin
    int waited;
    $display("[TB] plate_row_locator test start");
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    // First vsync only arms the block; the monitor flags any pulse here.
    vsync_pulse();

    // Single band rows 100..119, 60 edges per row.
    applyStimulus(100, 119, 200, 259, -1, -2, 0, 0, 0, -1, mk(1, 100, 119, 200, 259));
    // Ten-row run then a longer fifteen-row run: the longer one wins.
    applyStimulus(50, 59, 0, 29, 300, 314, 10, 39, 0, -1, mk(1, 300, 314, 10, 39));
    // Two ten-row runs: the upper one is kept.
    applyStimulus(50, 59, 0, 29, 80, 89, 100, 129, 0, -1, mk(1, 50, 59, 0, 29));
    // Five-row run is too short: nothing found, coordinates zero.
    applyStimulus(20, 24, 5, 40, -1, -2, 0, 0, 0, -1, mk(0, 0, 0, 0, 0));
    // Run on the last rows, last href fall coinciding with vsync rise.
    applyStimulus(470, 479, 5, 34, -1, -2, 0, 0, 1, -1, mk(1, 470, 479, 5, 34));
    // 19-edge rows do not qualify, 20-edge rows do.
    applyStimulus(10, 19, 0, 18, 30, 39, 0, 19, 0, -1, mk(1, 30, 39, 0, 19));
    // Reset at row 200 after a band already passed; nothing may be published.
    applyStimulus(100, 119, 200, 259, -1, -2, 0, 0, 0, 200, mk(0, 0, 0, 0, 0));
    vsync_pulse();
    applyStimulus(100, 119, 200, 259, -1, -2, 0, 0, 0, -1, mk(1, 100, 119, 200, 259));

    waited = 0;
    while (sb_q.size() != 0 && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput("drain_pending", 32'(sb_q.size()), 0);

    // Published values hold after the pulse.
    repeat (5) tick();
    checkOutput("hold_found", 32'(box_found), 1);
    checkOutput("hold_top",   32'(box_top),   100);
    checkOutput("hold_right", 32'(box_right), 259);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
